// File: rtl/slot_alloc_dec_if.sv
// Allocation/free bus for slot_alloc_dec: requester (master) and allocator (slave) views.
interface slot_alloc_dec_if #(parameter int IDX_W = 4);
  localparam int N = 2 ** IDX_W;

  logic             flush;
  logic             alloc_req;
  logic             alloc_gnt;
  logic [IDX_W-1:0] alloc_idx;
  logic [N-1:0]     alloc_onehot;
  logic             free_valid;
  logic [IDX_W-1:0] free_idx;
  logic [N-1:0]     busy_vec;
  logic [IDX_W:0]   count;
  logic             full;
  logic             empty;
  logic             free_err;

  modport master (
    output flush, alloc_req, free_valid, free_idx,
    input  alloc_gnt, alloc_idx, alloc_onehot, busy_vec, count, full, empty, free_err
  );

  modport slave (
    input  flush, alloc_req, free_valid, free_idx,
    output alloc_gnt, alloc_idx, alloc_onehot, busy_vec, count, full, empty, free_err
  );
endinterface

// File: rtl/slot_alloc_dec.sv
// Slot allocator over N = 2**IDX_W entries: grants the first free slot, releases by index.
// Optional macro SLOT_ALLOC_RR_EN switches selection to round-robin from rr_ptr.
module slot_alloc_dec #(
  parameter int IDX_W = 4
) (
  input logic             clk,
  input logic             reset,
  slot_alloc_dec_if.slave bus
);
  localparam int N     = 2 ** IDX_W;
  localparam int CNT_W = IDX_W + 1;

  logic [N-1:0]     busy_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic             free_err_r;

  logic [IDX_W-1:0] base_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_found_s;
  logic             gnt_s;
  logic             free_ok_s;
  logic             free_bad_s;
  logic [N-1:0]     busy_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;

`ifdef SLOT_ALLOC_RR_EN
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_ptr_nxt_s;

  assign base_s = rr_ptr_r;
`else
  assign base_s = {IDX_W{1'b0}};
`endif

  // Search for the first free slot starting at base_s, wrapping modulo N.
  always_comb begin
    sel_idx_s   = {IDX_W{1'b0}};
    sel_found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!sel_found_s && !busy_r[base_s + IDX_W'(i)]) begin
        sel_idx_s   = base_s + IDX_W'(i);
        sel_found_s = 1'b1;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign gnt_s      = bus.alloc_req & ~full_r & ~bus.flush & ~reset;
  assign free_ok_s  = bus.free_valid &  busy_r[bus.free_idx] & ~bus.flush;
  assign free_bad_s = bus.free_valid & ~busy_r[bus.free_idx] & ~bus.flush;

  // Next busy vector and count; the alloc set is applied after the free clear so alloc wins.
  always_comb begin
    busy_nxt_s  = busy_r;
    count_nxt_s = count_r;
    if (bus.flush) begin
      busy_nxt_s  = {N{1'b0}};
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      if (free_ok_s) begin
        busy_nxt_s[bus.free_idx] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (gnt_s) begin
        busy_nxt_s[sel_idx_s] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      count_nxt_s = count_r + CNT_W'(gnt_s) - CNT_W'(free_ok_s);
    end
  end

`ifdef SLOT_ALLOC_RR_EN
  // Round-robin pointer advances past each granted slot.
  always_comb begin
    rr_ptr_nxt_s = rr_ptr_r;
    if (bus.flush) begin
      rr_ptr_nxt_s = {IDX_W{1'b0}};
    end else if (gnt_s) begin
      rr_ptr_nxt_s = sel_idx_s + IDX_W'(1);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end
`endif

  // State and status registers; full/empty come from count_nxt_s to track busy_r exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= {N{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      free_err_r <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CNT_W'(N));
      empty_r    <= (count_nxt_s == {CNT_W{1'b0}});
      free_err_r <= free_bad_s;
    end
  end

  assign bus.alloc_gnt    = gnt_s;
  assign bus.alloc_idx    = sel_idx_s;
  assign bus.alloc_onehot = gnt_s ? ({{(N-1){1'b0}}, 1'b1} << sel_idx_s) : {N{1'b0}};
  assign bus.busy_vec     = busy_r;
  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.free_err     = free_err_r;
endmodule

// File: tb/tb_slot_alloc_dec.sv
// Self-checking bench for slot_alloc_dec (IDX_W=2): directed scenarios plus random traffic
// against a slot-array reference model.
module tb_slot_alloc_dec;
  localparam int IDX_W = 2;
  localparam int N     = 4;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  slot_alloc_dec_if #(.IDX_W(IDX_W)) bus ();
  slot_alloc_dec #(.IDX_W(IDX_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: which slots are held, the search start, and the pending error pulse
  bit   m_busy [N];
  int   m_ptr;
  bit   m_err;
  bit   p_gnt;
  int   p_idx;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i];
    return c;
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic set_in(input logic r, input logic f, input logic q, input logic v, input logic [1:0] fi);
    int start;
    reset = r; bus.flush = f; bus.alloc_req = q; bus.free_valid = v; bus.free_idx = fi;
`ifdef SLOT_ALLOC_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    p_idx = 0;
    for (int k = N - 1; k >= 0; k--)
      if (!m_busy[(start + k) % N]) p_idx = (start + k) % N;
    p_gnt = q && !f && !r && (m_count() != N);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset || bus.flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      m_err = bus.free_valid && !m_busy[bus.free_idx];
      if (bus.free_valid) m_busy[bus.free_idx] = 1'b0;
      if (p_gnt) begin
        m_busy[p_idx] = 1'b1;
        m_ptr = (p_idx + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    checks++; if (bus.alloc_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus.alloc_gnt); end
    tick();
    checks++;
    if (bus.busy_vec !== 4'b0000 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.free_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b count=%0d empty=%b full=%b err=%b exp busy=0000 count=0 empty=1 full=0 err=0",
               bus.busy_vec, bus.count, bus.empty, bus.full, bus.free_err);
    end
  endtask

  task automatic test_fill();
    logic [3:0] oh;
    for (int i = 0; i < N; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      #1;
      oh = 4'b0001 << i;
      checks++;
      if (bus.alloc_gnt !== 1'b1 || bus.alloc_idx !== 2'(i) || bus.alloc_onehot !== oh) begin
        failures++;
        $display("FAIL fill_grant%0d got gnt=%b idx=%0d oh=%b exp gnt=1 idx=%0d oh=%b", i, bus.alloc_gnt, bus.alloc_idx, bus.alloc_onehot, i, oh);
      end
      tick();
    end
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.busy_vec !== 4'b1111) begin
      failures++;
      $display("FAIL fill_full got full=%b count=%0d busy=%b exp full=1 count=4 busy=1111", bus.full, bus.count, bus.busy_vec);
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b0 || bus.alloc_onehot !== 4'b0000 || bus.alloc_idx !== 2'd0) begin
      failures++;
      $display("FAIL fill_fifth got gnt=%b oh=%b idx=%0d exp gnt=0 oh=0000 idx=0", bus.alloc_gnt, bus.alloc_onehot, bus.alloc_idx);
    end
  endtask

  task automatic test_full_free();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
    #1;
    checks++; if (bus.alloc_gnt !== 1'b0) begin failures++; $display("FAIL full_free_nobypass got gnt=%b exp=0", bus.alloc_gnt); end
    tick();
    checks++;
    if (bus.busy_vec !== 4'b1011 || bus.count !== 3'd3 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL full_free_state got busy=%b count=%0d full=%b exp busy=1011 count=3 full=0", bus.busy_vec, bus.count, bus.full);
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_idx !== 2'd2) begin
      failures++;
      $display("FAIL full_free_regrant got gnt=%b idx=%0d exp gnt=1 idx=2", bus.alloc_gnt, bus.alloc_idx);
    end
    tick();
  endtask

  task automatic test_alloc_free();
    do_reset();
    repeat (2) begin set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick(); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_idx !== 2'd2) begin
      failures++;
      $display("FAIL alloc_free_grant got gnt=%b idx=%0d exp gnt=1 idx=2", bus.alloc_gnt, bus.alloc_idx);
    end
    tick();
    checks++;
    if (bus.busy_vec !== 4'b0110 || bus.count !== 3'd2 || bus.free_err !== 1'b0) begin
      failures++;
      $display("FAIL alloc_free_state got busy=%b count=%0d err=%b exp busy=0110 count=2 err=0", bus.busy_vec, bus.count, bus.free_err);
    end
  endtask

  task automatic test_double_free();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 2'd3); tick();
    checks++;
    if (bus.busy_vec !== 4'b0001 || bus.count !== 3'd1 || bus.free_err !== 1'b1) begin
      failures++;
      $display("FAIL double_free_pulse got busy=%b count=%0d err=%b exp busy=0001 count=1 err=1", bus.busy_vec, bus.count, bus.free_err);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    checks++;
    if (bus.free_err !== 1'b0 || bus.busy_vec !== 4'b0001) begin
      failures++;
      $display("FAIL double_free_oneshot got err=%b busy=%b exp err=0 busy=0001", bus.free_err, bus.busy_vec);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    repeat (3) begin set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick(); end
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
    #1;
    checks++; if (bus.alloc_gnt !== 1'b0) begin failures++; $display("FAIL flush_gnt got gnt=%b exp=0", bus.alloc_gnt); end
    tick();
    checks++;
    if (bus.busy_vec !== 4'b0000 || bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.free_err !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got busy=%b empty=%b count=%0d err=%b exp busy=0000 empty=1 count=0 err=0",
               bus.busy_vec, bus.empty, bus.count, bus.free_err);
    end
    repeat (2) begin set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick(); end
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
    tick();
    checks++;
    if (bus.busy_vec !== 4'b0000 || bus.count !== 3'd0 || bus.free_err !== 1'b0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL midfill_reset got busy=%b count=%0d err=%b empty=%b exp busy=0000 count=0 err=0 empty=1",
               bus.busy_vec, bus.count, bus.free_err, bus.empty);
    end
  endtask

  task automatic test_selection_policy();
    logic [1:0] exp_idx;
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
`ifdef SLOT_ALLOC_RR_EN
    exp_idx = 2'd1;
`else
    exp_idx = 2'd0;
`endif
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_idx !== exp_idx) begin
      failures++;
      $display("FAIL policy_regrant got gnt=%b idx=%0d exp gnt=1 idx=%0d", bus.alloc_gnt, bus.alloc_idx, exp_idx);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_oh;
    for (int n = 0; n < 2000; n++) begin
      set_in(($urandom_range(49) == 0), ($urandom_range(29) == 0), 1'($urandom_range(2) != 0),
             1'($urandom_range(1)), 2'($urandom_range(3)));
      #1;
      exp_oh = p_gnt ? (4'b0001 << p_idx) : 4'b0000;
      checks++;
      if (bus.alloc_gnt !== p_gnt || bus.alloc_idx !== 2'(p_idx) || bus.alloc_onehot !== exp_oh) begin
        failures++;
        $display("FAIL rand_grant@%0d got gnt=%b idx=%0d oh=%b exp gnt=%b idx=%0d oh=%b",
                 n, bus.alloc_gnt, bus.alloc_idx, bus.alloc_onehot, p_gnt, p_idx, exp_oh);
      end
      tick();
      checks++;
      if (bus.busy_vec !== m_vec() || bus.count !== 3'(m_count()) || bus.full !== (m_count() == N) ||
          bus.empty !== (m_count() == 0) || bus.free_err !== m_err) begin
        failures++;
        $display("FAIL rand_state@%0d got busy=%b count=%0d full=%b empty=%b err=%b exp busy=%b count=%0d err=%b",
                 n, bus.busy_vec, bus.count, bus.full, bus.empty, bus.free_err, m_vec(), m_count(), m_err);
      end
    end
  endtask

  initial begin
    m_ptr = 0;
    m_err = 1'b0;
    test_reset();
    test_fill();
    test_full_free();
    test_alloc_free();
    test_double_free();
    test_flush_reset();
    test_selection_policy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
